// File: rtl/fifo_push_arbiter_if.sv
// Handshake bundle between the lane-side requesters, the push arbiter and the shared FIFO.
// The arbiter takes the slave view; producers plus the FIFO side take the master view.
interface fifo_push_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_last_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic                   fifo_full_i;
  logic                   fifo_push_o;
  logic [IDW+WIDTH-1:0]   fifo_wdata_o;
  logic                   fifo_clear_o;
  logic                   flush_i;
  logic                   flush_done_o;
  logic [N_REQ-1:0]       abort_o;
  logic                   busy_o;
  logic [IDW-1:0]         owner_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, fifo_full_i, flush_i,
    output req_ready_o, fifo_push_o, fifo_wdata_o, fifo_clear_o,
           flush_done_o, abort_o, busy_o, owner_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, fifo_full_i, flush_i,
    input  req_ready_o, fifo_push_o, fifo_wdata_o, fifo_clear_o,
           flush_done_o, abort_o, busy_o, owner_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin, packet-granular write arbiter in front of a shared FIFO.
// Tags each pushed beat with its source ID and sequences flushes that drop in-flight packets.
module fifo_push_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fifo_push_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [IDW-1:0]   LAST_ID  = IDW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e         state_r, state_nxt_s;
  logic [IDW-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic [IDW-1:0] owner_r, owner_nxt_s;
  logic           drop_r, drop_nxt_s;

  logic           scan_found_s;
  logic [IDW-1:0] scan_id_s;
  logic [IDW:0]   cand_s;
  logic           grant_vld_s;
  logic [IDW-1:0] grant_id_s;
  logic           open_s;
  logic           accept_s;
  logic           last_s;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == LAST_ID) begin
      next_id = {IDW{1'b0}};
    end else begin
      next_id = id + IDW'(1);
    end
  endfunction

  // Round-robin scan: first valid requester at or after rr_ptr, modulo N_REQ.
  always_comb begin
    scan_found_s = 1'b0;
    scan_id_s    = rr_ptr_r;
    cand_s       = {(IDW+1){1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDW+1)'(i);
      if (cand_s >= (IDW+1)'(N_REQ)) begin
        cand_s = cand_s - (IDW+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!scan_found_s && bus.req_valid_i[cand_s[IDW-1:0]]) begin
        scan_found_s = 1'b1;
        scan_id_s    = cand_s[IDW-1:0];
      end else begin
        scan_found_s = scan_found_s;
      end
    end
  end

  // Grant selection: the scan winner when idle, the locked owner mid-packet.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = owner_r;
    case (state_r)
      ST_IDLE: begin
        grant_vld_s = scan_found_s;
        grant_id_s  = scan_id_s;
      end
      ST_BURST: begin
        grant_vld_s = 1'b1;
        grant_id_s  = owner_r;
      end
      default: begin
        grant_vld_s = 1'b0;
        grant_id_s  = owner_r;
      end
    endcase
  end

  // Ready is gated by reset too, so nothing is accepted while rst_i is held.
  assign open_s   = grant_vld_s & ~bus.fifo_full_i & (state_r != ST_FLUSH) & ~bus.flush_i & ~rst_i;
  assign accept_s = open_s & bus.req_valid_i[grant_id_s];
  assign last_s   = bus.req_last_i[grant_id_s];

  // Next-state, pointer and ownership update.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    owner_nxt_s  = owner_r;
    drop_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.flush_i) begin
          state_nxt_s = ST_FLUSH;
        end else if (accept_s) begin
          if (last_s) begin
            rr_ptr_nxt_s = next_id(grant_id_s);
          end else begin
            state_nxt_s = ST_BURST;
            owner_nxt_s = grant_id_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (bus.flush_i) begin
          state_nxt_s = ST_FLUSH;
          drop_nxt_s  = 1'b1;
        end else if (accept_s && last_s) begin
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = next_id(owner_r);
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_i) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= {IDW{1'b0}};
      owner_r  <= {IDW{1'b0}};
      drop_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      owner_r  <= owner_nxt_s;
      drop_r   <= drop_nxt_s;
    end
  end

  assign bus.req_ready_o  = open_s ? (ONE_HOT0 << grant_id_s) : {N_REQ{1'b0}};
  assign bus.fifo_push_o  = accept_s;
  assign bus.fifo_wdata_o = {grant_id_s, bus.req_data_i[int'(grant_id_s)*WIDTH +: WIDTH]};
  assign bus.fifo_clear_o = (state_r == ST_FLUSH);
  assign bus.flush_done_o = (state_r == ST_FLUSH);
  // drop_r remembers that the flush interrupted a packet, so only the owner gets aborted.
  assign bus.abort_o      = ((state_r == ST_FLUSH) && drop_r) ? (ONE_HOT0 << owner_r) : {N_REQ{1'b0}};
  assign bus.busy_o       = (state_r == ST_BURST);
  assign bus.owner_o      = owner_r;

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin write-side arbiter that shares one `fifo_sync` instance among `N_REQ` requesters. It grants whole packets, so beats from different sources are never interleaved. Each accepted beat is tagged with its source ID. It also sequences FIFO flushes, dropping any in-flight packet (drop_on_midreset handling). It sits between the lane-side producers and the shared FIFO, driving the FIFO's `push_i`, `wdata_i` and `clear_i`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 32: payload width per beat.
- `IDW`, default `$clog2(N_REQ)`: source-ID tag width.

Ports:
- `clk_i`  in  1: clock.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `req_valid_i`  in  N_REQ: per-requester beat valid.
- `req_last_i`  in  N_REQ: beat is last of packet.
- `req_data_i`  in  N_REQ*WIDTH: payload; requester k occupies bits [k*WIDTH +: WIDTH].
- `req_ready_o`  out  N_REQ: beat accepted when valid & ready.
- `fifo_full_i`  in  1: from FIFO `full_o`.
- `fifo_push_o`  out  1: to FIFO `push_i`.
- `fifo_wdata_o`  out  IDW+WIDTH: to FIFO `wdata_i`, formatted {src_id, payload}.
- `fifo_clear_o`  out  1: to FIFO `clear_i`.
- `flush_i`  in  1: flush request, level-sampled.
- `flush_done_o`  out  1: one-cycle pulse in the flush cycle.
- `abort_o`  out  N_REQ: one-hot pulse, with the flush, to the owner whose packet was dropped.
- `busy_o`  out  1: high in BURST.
- `owner_o`  out  IDW: locked owner; valid while `busy_o`.

## Operation
- States and registers:
  - States: IDLE, BURST, FLUSH.
  - Registers: `state`, `rr_ptr` (IDW), `owner` (IDW).
- Grant in IDLE (combinational):
  - Pick the first k with `req_valid_i[k]`, searching from `rr_ptr` upward modulo N_REQ.
  - If no requester is valid, there is no grant.
- Grant in BURST: only `owner` is granted.
- `req_ready_o[k]` = granted(k) & !`fifo_full_i` & (state != FLUSH) & !`flush_i`.
- `fifo_push_o` = OR over k of (`req_valid_i[k]` & `req_ready_o[k]`).
- `fifo_wdata_o` = {k, `req_data_i[k]`} for the accepted k. When there is no push, its value is don't-care.
- IDLE transitions:
  - Accepted beat with `last` set: stay in IDLE; `rr_ptr` <= k+1 (wraps at N_REQ to 0).
  - Accepted beat without `last`: go to BURST; `owner` <= k.
- BURST transitions:
  - Accepted beat with `last` set: go to IDLE; `rr_ptr` <= owner+1 (wraps).
  - Owner valid low, or `fifo_full_i` high: hold state; no other requester is granted.
- `flush_i` high in IDLE or BURST:
  - No beat is accepted that cycle.
  - Next state is FLUSH.
- FLUSH (exactly one cycle):
  - `fifo_clear_o`=1 and `flush_done_o`=1.
  - If entered from BURST, `abort_o[owner]`=1.
  - Next state is IDLE; `rr_ptr` is unchanged.
  - An aborted requester restarts its packet from beat 0.
- `flush_i` still high in FLUSH: enter FLUSH again next cycle. This gives a back-to-back clear; no abort is raised, since the previous state was FLUSH.
- `fifo_full_i` high: all ready outputs low; state and pointer hold.
- Requester ID-to-bit mapping is fixed: ID k corresponds to bit k of every per-requester vector.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, `rr_ptr`=0, `owner`=0.
  - All `req_ready_o`, `fifo_push_o`, `fifo_clear_o`, `flush_done_o`, `abort_o` and `busy_o` are 0 while `rst_i` is high.
- Latency:
  - Valid to push: 0 cycles (combinational).
  - Ownership and pointer updates: registered, effective on the next edge.
- `flush_i` to `fifo_clear_o`: 1 cycle.
- Back-to-back single-beat packets from different requesters are accepted on consecutive cycles.
- Reset mid-BURST returns to IDLE with no abort pulse. The FIFO is reset by the same reset.
- The requester must hold valid, last and data stable until ready. The arbiter does not check this.

## Test plan
- Round-robin fairness:
  - Stimulus: all four requesters valid, single-beat (last=1), FIFO not full, for 5 cycles.
  - Response: pushes tagged ID 0,1,2,3,0; `rr_ptr` after = 1.
- Packet lock:
  - Stimulus: req1 sends a 3-beat packet; req2 is valid from the cycle after req1's first beat.
  - Response: pushes 1,1,1 then 2; `busy_o`=1 and `owner_o`=1 across beats 2-3; `req_ready_o[2]`=0 until req1's last beat.
- Backpressure:
  - Stimulus: `fifo_full_i`=1 for 3 cycles mid-packet, with req0 valid.
  - Response: `fifo_push_o`=0 and ready=0 for those 3 cycles; the packet resumes with the same owner, and no beat is lost or duplicated.
- Flush mid-burst:
  - Stimulus: `flush_i` pulse after beat 2 of a 4-beat packet from req3.
  - Response: no accept in the flush_i cycle; the next cycle has `fifo_clear_o`=1, `flush_done_o`=1 and `abort_o`=4'b1000; then IDLE, with `busy_o`=0.
- Flush in IDLE:
  - Stimulus: `flush_i` held high for 2 cycles with no requester valid.
  - Response: `fifo_clear_o` high for 2 consecutive cycles; `abort_o`=0 throughout.
- Reset mid-burst:
  - Stimulus: assert `rst_i` during beat 2 of a req2 packet.
  - Response: all outputs 0 immediately; after release, req0 valid is granted first (`rr_ptr`=0); no abort pulse.
